// File: rtl/aes_pkg.sv
// Shared FSM encoding, round-constant table and AES byte-level helpers
// for the iterative AES-128 sequencer.
package aes_pkg;

  typedef enum logic [2:0] {S_IDLE, S_KSUB, S_SSUB, S_WAIT, S_MIX} fsm_e;

  // Round 1 constant sits in the most significant byte.
  localparam logic [79:0] RCON_TBL = 80'h01_02_04_08_10_20_40_80_1b_36;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h00;
    if (round >= 4'd1 && round <= 4'd10) r = RCON_TBL[8*(10-int'(round)) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Byte i (row i%4, column i/4) lives at bits [127-8*i -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] b);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = b[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] b);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = b[127-32*c -: 8];
      a1 = b[119-32*c -: 8];
      a2 = b[111-32*c -: 8];
      a3 = b[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational AES-128 key-schedule step: next round key from the
// current one and the SubWord(RotWord(w3)) result.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rkey_i,
  input  logic [31:0]  subword_i,
  input  logic [3:0]   round_i,
  output logic [127:0] rkey_o
);

  logic [31:0] t, w0, w1, w2, w3;

  always_comb begin
    t      = subword_i ^ {rcon(round_i), 24'h0};
    w0     = rkey_i[127:96] ^ t;
    w1     = rkey_i[95:64]  ^ w0;
    w2     = rkey_i[63:32]  ^ w1;
    w3     = rkey_i[31:0]   ^ w2;
    rkey_o = {w0, w1, w2, w3};
  end

endmodule

// File: rtl/subbytes.sv
// Registered 16-byte AES S-box array; LATENCY register stages from
// beforeSub to afterSub.
module subbytes #(
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic [127:0] beforeSub,
  output logic [127:0] afterSub
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as b^254 by square-and-multiply, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq, inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [127:0] sub_all;
  logic [127:0] pipe_q [LATENCY];

  always_comb begin
    sub_all = '0;
    for (int i = 0; i < 16; i++) sub_all[127-8*i -: 8] = sbox(beforeSub[127-8*i -: 8]);
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= sub_all;
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign afterSub = pipe_q[LATENCY-1];

endmodule

// File: rtl/aes_sub_sched.sv
// Iterative AES-128 encryptor sharing one registered S-box array between
// the key schedule (SubWord) and the state path (SubBytes) every round.
module aes_sub_sched
  import aes_pkg::*;
#(
  parameter int SUB_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  localparam logic [1:0] WAIT_LAST = 2'(SUB_LATENCY > 1 ? SUB_LATENCY - 2 : 0);

  fsm_e                   fsm_q, fsm_d;
  logic [127:0]           state_q, rkey_q, ct_q;
  logic [3:0]             round_q;
  logic [1:0]             wcnt_q;
  logic                   busy_q, done_q;
  logic [SUB_LATENCY-1:0] ksub_q;
  logic [127:0]           before_sub, after_sub, rkey_next, sr, mix_out;

  subbytes #(.LATENCY(SUB_LATENCY)) u_sub (
    .clk       (clk),
    .beforeSub (before_sub),
    .afterSub  (after_sub)
  );

  aes_key_step u_key (
    .rkey_i    (rkey_q),
    .subword_i (after_sub[31:0]),
    .round_i   (round_q),
    .rkey_o    (rkey_next)
  );

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= S_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      S_IDLE:  if (start) fsm_d = S_KSUB;
      S_KSUB:  fsm_d = S_SSUB;
      S_SSUB:  fsm_d = (SUB_LATENCY == 1) ? S_MIX : S_WAIT;
      S_WAIT:  if (wcnt_q == WAIT_LAST) fsm_d = S_MIX;
      S_MIX:   fsm_d = (round_q == 4'd10) ? S_IDLE : S_KSUB;
      default: fsm_d = S_IDLE;
    endcase
  end

  // Only KSUB and SSUB feed the S-box; it sees zero otherwise so key and
  // state results never overlap in the pipeline.
  always_comb begin
    before_sub = '0;
    if (!rst) begin
      unique case (fsm_q)
        S_KSUB:  before_sub = {96'h0, rot_word(rkey_q[31:0])};
        S_SSUB:  before_sub = state_q;
        default: before_sub = '0;
      endcase
    end
  end

  always_comb begin
    sr      = shift_rows(after_sub);
    mix_out = ((round_q == 4'd10) ? sr : mix_columns(sr)) ^ rkey_q;
  end

  // ksub_q tracks the SubWord request through the S-box pipeline so the key
  // result is captured exactly SUB_LATENCY cycles after KSUB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      rkey_q  <= '0;
      ct_q    <= '0;
      round_q <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ksub_q  <= '0;
    end else begin
      done_q <= 1'b0;
      for (int i = SUB_LATENCY - 1; i > 0; i--) ksub_q[i] <= ksub_q[i-1];
      ksub_q[0] <= (fsm_q == S_KSUB);
      wcnt_q    <= (fsm_q == S_WAIT) ? wcnt_q + 2'd1 : 2'd0;
      if (ksub_q[SUB_LATENCY-1]) rkey_q <= rkey_next;
      unique case (fsm_q)
        S_IDLE: if (start) begin
          state_q <= plaintext ^ key;
          rkey_q  <= key;
          round_q <= 4'd1;
          busy_q  <= 1'b1;
        end
        S_MIX: begin
          state_q <= mix_out;
          if (round_q == 4'd10) begin
            ct_q   <= mix_out;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_sub_sched.sv
// Bench for aes_sub_sched: one instance at SUB_LATENCY=1 and one at 2 share
// stimulus; a transaction-level AES model predicts busy/done/ciphertext.
module tb_aes_sub_sched;

  localparam logic [127:0] KEY1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK2_1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam int LAT_A = 10 * (1 + 2);
  localparam int LAT_B = 10 * (2 + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start;
  logic [127:0] pt, key;
  logic         busy_a, done_a, busy_b, done_b;
  logic [127:0] ct_a, ct_b;

  aes_sub_sched dut_a (
    .clk(clk), .rst(rst), .start(start), .plaintext(pt), .key(key),
    .busy(busy_a), .done(done_a), .ciphertext(ct_a)
  );

  aes_sub_sched #(.SUB_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .plaintext(pt), .key(key),
    .busy(busy_b), .done(done_b), .ciphertext(ct_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  logic [7:0] sbox_tbl [256];

  logic         m_busy [2];
  logic         m_done [2];
  logic [127:0] m_ct   [2];
  logic [127:0] m_pend [2];
  int           m_left [2];
  int           dcnt   [2];
  int           bcnt   [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Plain polynomial multiply then reduction by 0x11b.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int j = 15; j >= 8; j--) if (p[j]) p = p ^ (16'h011b << (j - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_tbl[x] = s;
    end
  endtask

  function automatic void expand(input logic [127:0] k, output logic [31:0] w [44]);
    logic [7:0]  rc;
    logic [31:0] t;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
    logic [31:0] w [44];
    expand(k, w);
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    expand(k, w);
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tbl[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++)
            t[row+4*c] = gm(8'h02, s[row+4*c]) ^ gm(8'h03, s[(row+1)%4+4*c]) ^
                         s[(row+2)%4+4*c] ^ s[(row+3)%4+4*c];
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Transaction model: accept when idle, done a fixed number of edges later.
  initial for (int i = 0; i < 2; i++) begin
    m_busy[i] = 1'b0; m_done[i] = 1'b0; m_ct[i] = '0; m_pend[i] = '0;
    m_left[i] = 0; dcnt[i] = 0; bcnt[i] = 0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0; m_done[i] = 1'b0; m_ct[i] = '0; m_left[i] = 0;
      end else begin
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_busy[i] = 1'b0; m_done[i] = 1'b1; m_ct[i] = m_pend[i];
          end
        end else if (start) begin
          m_busy[i] = 1'b1;
          m_left[i] = (i == 0) ? LAT_A : LAT_B;
          m_pend[i] = aes_enc(pt, key);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_a", 128'(busy_a), 128'(m_busy[0]));
      check("done_a", 128'(done_a), 128'(m_done[0]));
      check("ct_a",   ct_a,         m_ct[0]);
      check("busy_b", 128'(busy_b), 128'(m_busy[1]));
      check("done_b", 128'(done_b), 128'(m_done[1]));
      check("ct_b",   ct_b,         m_ct[1]);
      if (done_a) dcnt[0]++;
      if (done_b) dcnt[1]++;
      if (busy_a) bcnt[0]++;
      if (busy_b) bcnt[1]++;
    end
  end

  task automatic go(input logic [127:0] p, input logic [127:0] k);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin dcnt[i] = 0; bcnt[i] = 0; end
    pt = p; key = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k;
    k = 0;
    while ((m_busy[0] || m_busy[1]) && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, 128'(k < bound), 128'(1));
    @(negedge clk);
  endtask

  initial begin
    int k;
    build_sbox();
    check("model_sbox_00", 128'(sbox_tbl[0]), 128'(8'h63));
    check("model_sbox_53", 128'(sbox_tbl[8'h53]), 128'(8'hed));
    rst = 1'b1; start = 1'b0; pt = '0; key = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy_a", 128'(busy_a), 128'(0));
    check("rst_done_a", 128'(done_a), 128'(0));
    check("rst_ct_b", ct_b, 128'(0));
    rst = 1'b0;

    // Vector 1: 30 busy cycles at latency 1, 40 at latency 2.
    go(PT1, KEY1);
    wait_idle("t1_timeout", 120);
    check("t1_model_ct", m_ct[0], CT1);
    check("t1_ct_a", ct_a, CT1);
    check("t1_ct_b", ct_b, CT1);
    check("t1_busy_cycles_a", 128'(bcnt[0]), 128'(30));
    check("t1_busy_cycles_b", 128'(bcnt[1]), 128'(40));
    check("t1_dones_a", 128'(dcnt[0]), 128'(1));

    // Vector 2 and the first expanded round key.
    go(PT2, KEY2);
    repeat (3) @(negedge clk);
    check("t2_model_rk1", round_key(KEY2, 1), RK2_1);
    check("t2_rkey_a", dut_a.rkey_q, RK2_1);
    check("t2_rkey_b", dut_b.rkey_q, RK2_1);
    wait_idle("t2_timeout", 120);
    check("t2_ct_a", ct_a, CT2);
    check("t2_ct_b", ct_b, CT2);

    // Back-to-back: next start in the done cycle of the latency-1 instance.
    go(PT1, KEY1);
    k = 0;
    while (!m_done[0] && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("t3_first_done", 128'(done_a), 128'(1));
    pt = PT2; key = KEY2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_busy_nogap", 128'(busy_a), 128'(1));
    check("t3_ct_held", ct_a, CT1);
    wait_idle("t3_timeout", 200);
    check("t3_ct_a", ct_a, CT2);
    check("t3_ct_b", ct_b, CT1);
    check("t3_dones_a", 128'(dcnt[0]), 128'(2));
    check("t3_dones_b", 128'(dcnt[1]), 128'(1));

    // Starts at cycles 5 and 17 of a busy operation are ignored.
    go(PT2, KEY2);
    repeat (4) @(negedge clk);
    pt = PT1; key = KEY1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("t4_timeout", 120);
    check("t4_dones_a", 128'(dcnt[0]), 128'(1));
    check("t4_dones_b", 128'(dcnt[1]), 128'(1));
    check("t4_ct_a", ct_a, CT2);
    check("t4_ct_b", ct_b, CT2);

    // Reset at cycle 12 together with start aborts everything.
    go(PT1, KEY1);
    repeat (11) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("t5_rst_busy_a", 128'(busy_a), 128'(0));
    check("t5_rst_ct_a", ct_a, 128'(0));
    check("t5_rst_busy_b", 128'(busy_b), 128'(0));
    check("t5_rst_ct_b", ct_b, 128'(0));
    repeat (45) @(negedge clk);
    check("t5_no_done_a", 128'(dcnt[0]), 128'(0));
    check("t5_no_done_b", 128'(dcnt[1]), 128'(0));
    go(PT2, KEY2);
    wait_idle("t5_timeout", 120);
    check("t5_ct_a", ct_a, CT2);
    check("t5_ct_b", ct_b, CT2);
    check("t5_dones_a", 128'(dcnt[0]), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
